// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB
// first, stop bit; every bit held DIV cycles, all state on negedge CK.
//
// Ports:
//   CK   - clock, state updates on the falling edge
//   CLR  - asynchronous active-low reset
//   LOAD - start request, accepted only while idle
//   DIN  - parallel word, captured on the accepting edge
//   SOUT - serial line, idles high
//   BUSY - high while a frame is in progress
//   DONE - one-cycle pulse on the first idle cycle after a frame
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CK,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick;

  // Last cycle of the current bit period.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    unique case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (LOAD) begin
          sh_d    = DIN;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so the line
  // only moves on bit boundaries and nothing is combinational from LOAD.
  always_comb begin
    sout_d = 1'b1;
    unique case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = sh_d[0];
      default: sout_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(negedge CK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SOUT = sout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a WIDTH=8/DIV=4 instance driven from vector
// tables and a WIDTH=4/DIV=1 instance driven by a hand-written sequence.
module tb_serial_tx;

  logic       CK;
  logic       CLR;
  logic       LOAD_8;
  logic [7:0] DIN_8;
  logic       SOUT_8, BUSY_8, DONE_8;
  logic       LOAD_4;
  logic [3:0] DIN_4;
  logic       SOUT_4, BUSY_4, DONE_4;

  int checks = 0;
  int errors = 0;
  int vidx   = 0;

  typedef struct {
    logic       load;
    logic [7:0] din;
    logic       sout;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vq[$];

  serial_tx #(.WIDTH(8), .DIV(4)) u8 (
    .CK(CK), .CLR(CLR), .LOAD(LOAD_8), .DIN(DIN_8),
    .SOUT(SOUT_8), .BUSY(BUSY_8), .DONE(DONE_8)
  );

  serial_tx #(.WIDTH(4), .DIV(1)) u4 (
    .CK(CK), .CLR(CLR), .LOAD(LOAD_4), .DIN(DIN_4),
    .SOUT(SOUT_4), .BUSY(BUSY_4), .DONE(DONE_4)
  );

  initial CK = 1'b1;
  always #5 CK = ~CK;

  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic push(input logic ld, input logic [7:0] d,
                      input logic s, input logic b, input logic dn);
    vec_t v;
    v.load = ld;
    v.din  = d;
    v.sout = s;
    v.busy = b;
    v.done = dn;
    vq.push_back(v);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // One frame of the 8-bit/DIV=4 instance: k=0 is the accepting edge,
  // k=40 the return to idle with DONE. LOAD is held when hold=1, pulsed
  // at pulse_at otherwise; DIN shows alt after the accepting edge.
  task automatic add_frame(input logic [7:0] word, input bit hold,
                           input int pulse_at, input logic [7:0] alt,
                           input int ncyc);
    int   b;
    logic ld, s;
    for (int k = 0; k < ncyc && k <= 40; k++) begin
      ld = (k == 0) || hold || (k == pulse_at);
      if (k == 40) begin
        push(ld, alt, 1'b1, 1'b0, 1'b1);
      end else begin
        b = k / 4;
        if (b == 0)      s = 1'b0;
        else if (b <= 8) s = word[b-1];
        else             s = 1'b1;
        push(ld, (k == 0) ? word : alt, s, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic apply_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      LOAD_8 = vq[i].load;
      DIN_8  = vq[i].din;
      @(negedge CK);
      @(posedge CK);
      chk($sformatf("v%0d.sout", vidx), SOUT_8, vq[i].sout);
      chk($sformatf("v%0d.busy", vidx), BUSY_8, vq[i].busy);
      chk($sformatf("v%0d.done", vidx), DONE_8, vq[i].done);
      vidx++;
    end
    vq.delete();
    LOAD_8 = 1'b0;
  endtask

  logic [5:0] e4;

  initial begin
    CLR    = 1'b1;
    LOAD_8 = 1'b0;
    DIN_8  = 8'h00;
    LOAD_4 = 1'b0;
    DIN_4  = 4'h0;

    // Asynchronous reset before any clock edge, with junk on the inputs.
    #1;
    CLR    = 1'b0;
    LOAD_8 = 1'b1;
    DIN_8  = 8'($urandom);
    LOAD_4 = 1'b1;
    DIN_4  = 4'($urandom);
    #1;
    chk("rst.sout8", SOUT_8, 1'b1);
    chk("rst.busy8", BUSY_8, 1'b0);
    chk("rst.done8", DONE_8, 1'b0);
    chk("rst.sout4", SOUT_4, 1'b1);
    chk("rst.busy4", BUSY_4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CK);
      chk("rsthold.busy8", BUSY_8, 1'b0);
      chk("rsthold.sout8", SOUT_8, 1'b1);
      chk("rsthold.busy4", BUSY_4, 1'b0);
    end
    CLR    = 1'b1;
    LOAD_8 = 1'b0;
    LOAD_4 = 1'b0;

    // Idle after release, then plain frame, ignored LOAD, back-to-back.
    add_idle(3);
    add_frame(8'hA5, 1'b0, -1, 8'hA5, 41);
    add_idle(2);
    add_frame(8'hA5, 1'b0, 10, 8'hFF, 41);
    add_idle(3);
    add_frame(8'h01, 1'b1, -1, 8'h80, 41);
    add_frame(8'h80, 1'b1, -1, 8'h80, 41);
    add_idle(3);
    apply_vecs();

    // Reset 17 cycles into a frame: immediate abort, no DONE afterwards.
    add_frame(8'h5A, 1'b0, -1, 8'h5A, 17);
    apply_vecs();
    CLR = 1'b0;
    #1;
    chk("abort.sout", SOUT_8, 1'b1);
    chk("abort.busy", BUSY_8, 1'b0);
    chk("abort.done", DONE_8, 1'b0);
    @(negedge CK);
    @(posedge CK);
    chk("abort2.busy", BUSY_8, 1'b0);
    CLR = 1'b1;
    add_idle(4);
    add_frame(8'h3C, 1'b0, -1, 8'h3C, 41);
    add_idle(2);
    apply_vecs();

    // DIV=1, WIDTH=4: one cycle per bit.
    e4     = 6'b101100;
    LOAD_4 = 1'b1;
    DIN_4  = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      @(negedge CK);
      @(posedge CK);
      LOAD_4 = 1'b0;
      chk($sformatf("d1.sout%0d", i), SOUT_4, e4[i]);
      chk($sformatf("d1.busy%0d", i), BUSY_4, 1'b1);
      chk($sformatf("d1.done%0d", i), DONE_4, 1'b0);
    end
    @(negedge CK);
    @(posedge CK);
    chk("d1.done", DONE_4, 1'b1);
    chk("d1.idle_busy", BUSY_4, 1'b0);
    chk("d1.idle_sout", SOUT_4, 1'b1);
    @(negedge CK);
    @(posedge CK);
    chk("d1.done_off", DONE_4, 1'b0);
    chk("d1.busy_off", BUSY_4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
